// File: rtl/yutorina_rst_seq_pkg.sv
// Shared encodings for the reset sequencer: polarity levels, FSM states and reset-cause codes.
package yutorina_rst_seq_pkg;

    localparam logic ENABLE       = 1'b1;
    localparam logic DISABLE      = 1'b0;
    localparam logic RESET_ENABLE = 1'b1;

    localparam logic [2:0] ST_HOLD      = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STRETCH   = 3'd2;
    localparam logic [2:0] ST_RELEASE   = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_SW   = 2'b01;
    localparam logic [1:0] CAUSE_LOCK = 2'b10;

endpackage

// File: rtl/yutorina_sync_db.sv
// Multi-flop synchroniser with an optional debounce filter (DEBOUNCE_CYC=0 bypasses the filter).
module yutorina_sync_db #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 0,
    parameter int unsigned CNT_W        = 16,
    parameter logic        RST_VAL      = 1'b0
) (
    input  logic clk,
    input  logic rst_,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYC == 0) begin : g_nodb
            assign sync_o = sync_s;
        end else begin : g_db
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             db_q, db_d;

            // Accept a new level only after DEBOUNCE_CYC consecutive differing samples.
            always_comb begin
                cnt_d = '0;
                db_d  = db_q;
                if (sync_s != db_q) begin
                    if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                        db_d = sync_s;
                    end else if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_) begin
                    cnt_q <= '0;
                    db_q  <= RST_VAL;
                end else begin
                    cnt_q <= cnt_d;
                    db_q  <= db_d;
                end
            end

            assign sync_o = db_q;
        end
    endgenerate

endmodule

// File: rtl/yutorina_rst_seq.sv
// Reset sequencer: waits for a debounced switch release and a stretched lock, then releases
// NUM_DOM domain resets in order, STAGGER_CYC apart; any abort re-asserts every domain at once.
module yutorina_rst_seq
    import yutorina_rst_seq_pkg::*;
#(
    parameter int unsigned NUM_DOM      = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 1024,
    parameter int unsigned STRETCH_CYC  = 256,
    parameter int unsigned STAGGER_CYC  = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               rst_sw,
    input  logic               locked,
    output logic [NUM_DOM-1:0] dom_rst,
    output logic               seq_done,
    output logic [1:0]         rst_cause
);

    localparam int unsigned IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    logic               sw_db, lk_s;
    logic               sw_req_c, abort_c, release_c;
    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_DOM-1:0] dom_rst_q, dom_rst_d;
    logic               seq_done_q, seq_done_d;
    logic [1:0]         rst_cause_q, rst_cause_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    yutorina_sync_db #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .CNT_W       (CNT_W),
        .RST_VAL     (RESET_ENABLE)
    ) u_sw_sync (
        .clk    (clk),
        .rst_   (rst_),
        .async_i(rst_sw),
        .sync_o (sw_db)
    );

    yutorina_sync_db #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_CYC(0),
        .CNT_W       (CNT_W),
        .RST_VAL     (1'b0)
    ) u_lk_sync (
        .clk    (clk),
        .rst_   (rst_),
        .async_i(locked),
        .sync_o (lk_s)
    );

    assign sw_req_c = (sw_db == RESET_ENABLE);
    assign abort_c  = (state_q != ST_HOLD) &&
                      (sw_req_c || (!lk_s && (state_q == ST_RELEASE || state_q == ST_RUN)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        dom_rst_d   = dom_rst_q;
        seq_done_d  = seq_done_q;
        rst_cause_d = rst_cause_q;
        release_c   = 1'b0;

        case (state_q)
            ST_HOLD: begin
                cnt_d      = '0;
                idx_d      = '0;
                dom_rst_d  = {NUM_DOM{ENABLE}};
                seq_done_d = DISABLE;
                if (!sw_req_c) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (lk_s) begin
                    state_d = ST_STRETCH;
                end
            end
            ST_STRETCH: begin
                if (!lk_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STRETCH_CYC - 1)) begin
                    // Domain 0 is released on the same edge that leaves STRETCH.
                    cnt_d     = '0;
                    idx_d     = '0;
                    release_c = 1'b1;
                    if (NUM_DOM == 1) begin
                        state_d    = ST_RUN;
                        seq_done_d = ENABLE;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_RELEASE: begin
                if (cnt_q == CNT_W'(STAGGER_CYC - 1)) begin
                    cnt_d     = '0;
                    idx_d     = IDX_W'(idx_q + IDX_W'(1));
                    release_c = 1'b1;
                    if (idx_d == IDX_W'(NUM_DOM - 1)) begin
                        state_d    = ST_RUN;
                        seq_done_d = ENABLE;
                    end
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_RUN: begin
                cnt_d      = '0;
                dom_rst_d  = {NUM_DOM{DISABLE}};
                seq_done_d = ENABLE;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        // Switch request outranks lock loss when both are seen in the same cycle.
        if (abort_c) begin
            state_d     = ST_HOLD;
            cnt_d       = '0;
            idx_d       = '0;
            dom_rst_d   = {NUM_DOM{ENABLE}};
            seq_done_d  = DISABLE;
            rst_cause_d = sw_req_c ? CAUSE_SW : CAUSE_LOCK;
            release_c   = 1'b0;
        end

        if (release_c) begin
            for (int unsigned i = 0; i < NUM_DOM; i++) begin
                dom_rst_d[i] = (IDX_W'(i) <= idx_d) ? DISABLE : ENABLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            dom_rst_q   <= {NUM_DOM{ENABLE}};
            seq_done_q  <= DISABLE;
            rst_cause_q <= CAUSE_POR;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            dom_rst_q   <= dom_rst_d;
            seq_done_q  <= seq_done_d;
            rst_cause_q <= rst_cause_d;
        end
    end

    assign dom_rst   = dom_rst_q;
    assign seq_done  = seq_done_q;
    assign rst_cause = rst_cause_q;

endmodule
